// File: rtl/traffic_input_cond.sv
// Input conditioning for the traffic controller: 2-flop sync + debounce per raw input,
// latched walk request, and a restartable periodic timing tick.

module tic_debounce #(
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic [1:0]     sync_q;
  logic [DBW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync_q[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + DBW'(1);
      end
    end
  end

  // Asserted in the cycle whose closing edge accepts a 0->1 change, so the
  // request latch updates on the same edge as the debounced level.
  assign rise = sync_q[1] & ~level & (cnt == DB_LAST);
endmodule

module traffic_input_cond #(
  parameter int DB_CYCLES   = 2_000_000,
  parameter int TICK_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ped_btn_raw,
  input  logic traf_sense_raw,
  input  logic ped_ack,
  input  logic tick_sync,
  output logic ped_btn,
  output logic traf_sense,
  output logic sec_tick
);
  localparam int NUM_IN = 2;
  localparam int TW = $clog2(TICK_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [NUM_IN-1:0] raw_vec, lvl, rise;
  logic              unused_rise;
  logic [TW-1:0]     tick_cnt;

  assign raw_vec = {traf_sense_raw, ped_btn_raw};

  genvar g;
  generate
    for (g = 0; g < NUM_IN; g++) begin : g_db
      tic_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk   (clk),
        .rst   (rst),
        .raw   (raw_vec[g]),
        .level (lvl[g]),
        .rise  (rise[g])
      );
    end
  endgenerate

  assign traf_sense  = lvl[1];
  assign unused_rise = rise[1];

  // Press event beats a simultaneous acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ped_btn <= 1'b0;
    else if (rise[0]) ped_btn <= 1'b1;
    else if (ped_ack) ped_btn <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      sec_tick <= 1'b0;
    end else if (tick_sync) begin
      tick_cnt <= '0;
      sec_tick <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      sec_tick <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
      sec_tick <= 1'b0;
    end
  end
endmodule

// File: tb/tb_traffic_input_cond.sv
// Directed bench for traffic_input_cond with a cycle-stamped expectation queue
// drained by an independent negedge monitor.

module tb_traffic_input_cond;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ped_btn_raw = 1'b0, traf_sense_raw = 1'b0, ped_ack = 1'b0, tick_sync = 1'b0;
  logic ped_btn, traf_sense, sec_tick;

  traffic_input_cond #(.DB_CYCLES(4), .TICK_CYCLES(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .ped_btn_raw    (ped_btn_raw),
    .traf_sense_raw (traf_sense_raw),
    .ped_ack        (ped_ack),
    .tick_sync      (tick_sync),
    .ped_btn        (ped_btn),
    .traf_sense     (traf_sense),
    .sec_tick       (sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    int    sig;   // 0 ped_btn, 1 traf_sense, 2 sec_tick
    logic  val;
    string name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic mon_act;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push(int c, int s, logic v, string n);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    i = exp_q.size();
    while (i > 0 && exp_q[i-1].cyc > c) i--;
    exp_q.insert(i, e);
  endfunction

  function automatic void ex(int dt, int s, logic v, string n);
    push(cyc + dt, s, v, n);
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      case (mon_e.sig)
        0:       mon_act = ped_btn;
        1:       mon_act = traf_sense;
        default: mon_act = sec_tick;
      endcase
      total++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d want_cyc=%0d got=%b want=%b",
                 mon_e.name, cyc, mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  task automatic tk(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tk(3);
    rst = 1'b0;
    ex(0, 0, 1'b0, "rst_ped"); ex(0, 1, 1'b0, "rst_traf"); ex(0, 2, 1'b0, "rst_tick");
    tk(2);

    // clean press, latch survives release, ack clears, idle ack harmless
    ped_btn_raw = 1'b1;
    ex(5, 0, 1'b0, "press_pre"); ex(6, 0, 1'b1, "press_rise");
    tk(20);
    ped_btn_raw = 1'b0;
    ex(10, 0, 1'b1, "press_latched_after_release");
    tk(12);
    ped_ack = 1'b1;
    ex(0, 0, 1'b1, "ack_pre"); ex(1, 0, 1'b0, "ack_clear");
    tk(1); ped_ack = 1'b0;
    tk(3); ped_ack = 1'b1;
    ex(1, 0, 1'b0, "ack_idle_noeffect");
    tk(1); ped_ack = 1'b0;
    tk(3);

    // bounce 1,0,0,1,1,1,0 then hold 1: accepted 13 edges after first step
    ex(9, 0, 1'b0, "bounce_early"); ex(12, 0, 1'b0, "bounce_pre"); ex(13, 0, 1'b1, "bounce_accept");
    ped_btn_raw = 1'b1; tk(1);
    ped_btn_raw = 1'b0; tk(2);
    ped_btn_raw = 1'b1; tk(3);
    ped_btn_raw = 1'b0; tk(1);
    ped_btn_raw = 1'b1; tk(10);
    ex(0, 0, 1'b1, "bounce_single");
    ped_ack = 1'b1;
    ex(1, 0, 1'b0, "held_ack_clear");
    tk(1); ped_ack = 1'b0;
    ex(8, 0, 1'b0, "held_stays_low");
    tk(10);
    ped_btn_raw = 1'b0;
    ex(8, 0, 1'b0, "release_no_req");
    tk(10);

    // re-press with ack landing on the press-event cycle
    ped_btn_raw = 1'b1;
    ex(5, 0, 1'b0, "coll_pre"); ex(6, 0, 1'b1, "coll_set_wins");
    tk(5); ped_ack = 1'b1;
    tk(1); ped_ack = 1'b0;
    tk(4);
    ex(0, 0, 1'b1, "coll_hold");

    // sensor: 3-cycle pulse rejected, 8-cycle pulse passed with 6-edge lag
    traf_sense_raw = 1'b1;
    ex(6, 1, 1'b0, "sense_short_a"); ex(7, 1, 1'b0, "sense_short_b");
    tk(3); traf_sense_raw = 1'b0;
    tk(8);
    traf_sense_raw = 1'b1;
    ex(5, 1, 1'b0, "sense_pre"); ex(6, 1, 1'b1, "sense_rise");
    ex(13, 1, 1'b1, "sense_fall_pre"); ex(14, 1, 1'b0, "sense_fall");
    tk(8); traf_sense_raw = 1'b0;
    tk(10);

    // async reset mid-operation with button held, then free-running tick
    ex(0, 0, 1'b1, "pre_rst_ped");
    tk(1);
    rst = 1'b1;
    ex(0, 0, 1'b0, "async_rst_ped"); ex(0, 1, 1'b0, "async_rst_traf"); ex(0, 2, 1'b0, "async_rst_tick");
    tk(1);
    rst = 1'b0;
    ex(5, 0, 1'b0, "held_after_rst_pre"); ex(6, 0, 1'b1, "held_after_rst_req");
    for (int k = 1; k <= 35; k++) ex(k, 2, (k % 10) == 0, "tick_free");
    tk(37);
    tick_sync = 1'b1;
    tk(1); tick_sync = 1'b0;
    for (int k = 0; k <= 11; k++) ex(k, 2, k == 10, "tick_after_sync");
    tk(19);
    // sync coincident with terminal count suppresses that tick
    tick_sync = 1'b1;
    ex(1, 2, 1'b0, "sync_over_wrap"); ex(10, 2, 1'b0, "wrap_sync_pre"); ex(11, 2, 1'b1, "wrap_sync_tick");
    tk(1); tick_sync = 1'b0;
    tk(14);

    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
